// File: rtl/alu3_seq.sv
// Sequential ALU: single-cycle add/logic/shift ops, iterative shift-add multiply and
// restoring divide, with a start/busy/done handshake and registered result and flags.
module alu3_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       fi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       fo
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  state_t             state_r, state_nxt_s;
  logic [CW-1:0]      cnt_r;
  logic [1:0]         op_r;
  logic [1:0]         fi_r;
  logic [WIDTH-1:0]   opnd_r;
  logic [2*WIDTH-1:0] work_r, work_nxt_s;
  logic               busy_r, done_r;
  logic [WIDTH-1:0]   res_r;
  logic [3:0]         fo_r;

  logic               long_s, cin_s, c_s, v_s, fin_c_s, fin_v_s;
  logic [CW-1:0]      n_s;
  logic [CW:0]        rn_s;
  logic [WIDTH-1:0]   b_eff_s, rol_s, ror_s, res_s, fin_res_s;
  logic [WIDTH:0]     add_s, shl_s, shr_s, sha_s, mul_sum_s, rem_sh_s, diff_s;
  logic               unused_fi_s;

  assign busy        = busy_r;
  assign done        = done_r;
  assign res         = res_r;
  assign fo          = fo_r;
  assign unused_fi_s = ^fi[3:2];

  function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] r, input logic v, input logic c);
    return {r[WIDTH-1], (r == {WIDTH{1'b0}}), v, c};
  endfunction

  // Single-cycle datapath and divide-by-zero shortcut, evaluated on the live inputs
  always_comb begin
    n_s     = b[CW-1:0];
    rn_s    = (CW+1)'(WIDTH) - {1'b0, n_s};
    b_eff_s = op[1] ? ~b : b;
    cin_s   = op[0] ? fi[0] : op[1];
    add_s   = {1'b0, a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, cin_s};
    shl_s   = {1'b0, a} << n_s;
    shr_s   = {a, 1'b0} >> n_s;
    sha_s   = $signed({a, 1'b0}) >>> n_s;
    rol_s   = (a << n_s) | (a >> rn_s);
    ror_s   = (a >> n_s) | (a << rn_s);
    res_s   = a;
    c_s     = fi[0];
    v_s     = fi[1];
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3: begin
        res_s = add_s[WIDTH-1:0];
        c_s   = add_s[WIDTH];
        v_s   = (a[WIDTH-1] == b_eff_s[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
      end
      4'h4: res_s = a & b;
      4'h5: res_s = a | b;
      4'h6: res_s = a ^ b;
      // A zero shift count leaves res=a and C=fi[0] from the defaults
      4'h7: begin
        if (n_s != {CW{1'b0}}) begin
          res_s = shl_s[WIDTH-1:0];
          c_s   = shl_s[WIDTH];
        end else begin
          res_s = a;
        end
      end
      4'h8: begin
        if (n_s != {CW{1'b0}}) begin
          res_s = shr_s[WIDTH:1];
          c_s   = shr_s[0];
        end else begin
          res_s = a;
        end
      end
      4'h9: begin
        if (n_s != {CW{1'b0}}) begin
          res_s = sha_s[WIDTH:1];
          c_s   = sha_s[0];
        end else begin
          res_s = a;
        end
      end
      4'hA: begin
        if (n_s != {CW{1'b0}}) begin
          res_s = rol_s;
          c_s   = rol_s[0];
        end else begin
          res_s = a;
        end
      end
      4'hB: begin
        if (n_s != {CW{1'b0}}) begin
          res_s = ror_s;
          c_s   = ror_s[WIDTH-1];
        end else begin
          res_s = a;
        end
      end
      4'hE: begin
        res_s = {WIDTH{1'b1}};
        v_s   = 1'b1;
      end
      4'hF: begin
        res_s = a;
        v_s   = 1'b1;
      end
      default: res_s = a;
    endcase
    long_s = (op[3:2] == 2'b11) && !(op[1] && (b == {WIDTH{1'b0}}));
  end

  // One multiply or divide iteration on the shared work register
  always_comb begin
    mul_sum_s = {1'b0, work_r[2*WIDTH-1:WIDTH]} + (work_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    rem_sh_s  = work_r[2*WIDTH-1:WIDTH-1];
    diff_s    = rem_sh_s - {1'b0, opnd_r};
    if (!op_r[1]) begin
      work_nxt_s = {mul_sum_s, work_r[WIDTH-1:1]};
    end else if (!diff_s[WIDTH]) begin
      work_nxt_s = {diff_s[WIDTH-1:0], work_r[WIDTH-2:0], 1'b1};
    end else begin
      work_nxt_s = {rem_sh_s[WIDTH-1:0], work_r[WIDTH-2:0], 1'b0};
    end
  end

  // Iterative results: low half holds product-low / quotient, high half product-high / remainder
  always_comb begin
    fin_res_s = work_r[WIDTH-1:0];
    fin_c_s   = fi_r[0];
    fin_v_s   = 1'b0;
    case (op_r)
      2'b00: begin
        fin_c_s = (work_r[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
        fin_v_s = fin_c_s;
      end
      2'b01: begin
        fin_res_s = work_r[2*WIDTH-1:WIDTH];
        fin_v_s   = fi_r[1];
      end
      2'b10: fin_res_s = work_r[WIDTH-1:0];
      2'b11: fin_res_s = work_r[2*WIDTH-1:WIDTH];
      default: fin_res_s = work_r[WIDTH-1:0];
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start && long_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CW'(WIDTH - 1)) begin
          state_nxt_s = FIN;
        end else begin
          state_nxt_s = RUN;
        end
      end
      FIN:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture, iteration and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r  <= {CW{1'b0}};
      op_r   <= 2'b00;
      fi_r   <= 2'b00;
      opnd_r <= {WIDTH{1'b0}};
      work_r <= {(2*WIDTH){1'b0}};
      busy_r <= 1'b0;
      done_r <= 1'b0;
      res_r  <= {WIDTH{1'b0}};
      fo_r   <= 4'h0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && long_s) begin
            op_r   <= op[1:0];
            fi_r   <= fi[1:0];
            opnd_r <= op[1] ? b : a;
            work_r <= {{WIDTH{1'b0}}, (op[1] ? a : b)};
            cnt_r  <= {CW{1'b0}};
            busy_r <= 1'b1;
          end else if (start) begin
            res_r  <= res_s;
            fo_r   <= pack_flags(res_s, v_s, c_s);
            done_r <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        RUN: begin
          work_r <= work_nxt_s;
          cnt_r  <= cnt_r + CW'(1);
        end
        FIN: begin
          res_r  <= fin_res_s;
          fo_r   <= pack_flags(fin_res_s, fin_v_s, fin_c_s);
          done_r <= 1'b1;
          busy_r <= 1'b0;
        end
        default: busy_r <= 1'b0;
      endcase
    end
  end
endmodule
